// File: rtl/pfpred_issue.sv
// Prefetch-prediction issue stage: holds one four-slot prediction packet and
// serialises its qualifying delta slots into single prefetch requests.
module pfpred_issue #(
  parameter int PFENTRY_W = 10,
  parameter int ROBID_W   = 7,
  parameter int DELTA_W   = 12,
  parameter int WEIGHT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pfmtocore_pred_valid,
  output logic                 pfmtocore_pred_retry,
  input  logic [PFENTRY_W-1:0] pfmtocore_pred_pfentry,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d0_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d0_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d0_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d1_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d1_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d1_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d2_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d2_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d2_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d3_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d3_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d3_w,
  input  logic [WEIGHT_W-1:0]  cfg_wthresh,
  output logic                 pfitocore_req_valid,
  input  logic                 pfitocore_req_retry,
  output logic [PFENTRY_W-1:0] pfitocore_req_pfentry,
  output logic [ROBID_W-1:0]   pfitocore_req_rid,
  output logic [DELTA_W-1:0]   pfitocore_req_delta,
  output logic [WEIGHT_W-1:0]  pfitocore_req_w,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_filtered
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               r_state;
  logic [PFENTRY_W-1:0] r_pfentry;
  logic [ROBID_W-1:0]   r_rid [4];
  logic [DELTA_W-1:0]   r_val [4];
  logic [WEIGHT_W-1:0]  r_w   [4];
  logic [3:0]           r_pend;
  logic [15:0]          r_issued;
  logic [15:0]          r_filtered;

  logic [ROBID_W-1:0]   w_in_rid [4];
  logic [DELTA_W-1:0]   w_in_val [4];
  logic [WEIGHT_W-1:0]  w_in_w   [4];
  logic [3:0]           w_new_mask;
  logic [2:0]           w_new_cnt;
  logic [2:0]           w_nfilt;
  logic [1:0]           w_sel;
  logic [3:0]           w_sel_bit;
  logic                 w_onehot;
  logic                 w_req_valid;
  logic                 w_out_xfer;
  logic                 w_pred_retry;
  logic                 w_accept;

  assign w_in_rid[0] = pfmtocore_pred_d0_rid;
  assign w_in_rid[1] = pfmtocore_pred_d1_rid;
  assign w_in_rid[2] = pfmtocore_pred_d2_rid;
  assign w_in_rid[3] = pfmtocore_pred_d3_rid;
  assign w_in_val[0] = pfmtocore_pred_d0_val;
  assign w_in_val[1] = pfmtocore_pred_d1_val;
  assign w_in_val[2] = pfmtocore_pred_d2_val;
  assign w_in_val[3] = pfmtocore_pred_d3_val;
  assign w_in_w[0]   = pfmtocore_pred_d0_w;
  assign w_in_w[1]   = pfmtocore_pred_d1_w;
  assign w_in_w[2]   = pfmtocore_pred_d2_w;
  assign w_in_w[3]   = pfmtocore_pred_d3_w;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    w_new_mask = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_new_mask[i] = (w_in_w[i] >= cfg_wthresh) && (w_in_val[i] != '0);
    end
  end

  assign w_new_cnt = {2'b00, w_new_mask[0]} + {2'b00, w_new_mask[1]}
                   + {2'b00, w_new_mask[2]} + {2'b00, w_new_mask[3]};
  assign w_nfilt   = 3'd4 - w_new_cnt;

  // Lowest-numbered pending slot is the one on the request bus.
  always_comb begin
    w_sel = 2'd0;
    if (!r_pend[0]) begin
      if (r_pend[1])      w_sel = 2'd1;
      else if (r_pend[2]) w_sel = 2'd2;
      else if (r_pend[3]) w_sel = 2'd3;
    end
  end

  assign w_sel_bit = 4'b0001 << w_sel;
  assign w_onehot  = (r_pend != 4'd0) && ((r_pend & (r_pend - 4'd1)) == 4'd0);

  // Everything is gated by reset so outputs read quiet while reset is low.
  assign w_req_valid  = (r_state == ISSUE) && reset;
  assign w_out_xfer   = w_req_valid && !pfitocore_req_retry;
  assign w_pred_retry = (r_state == ISSUE) && reset && !(w_onehot && !pfitocore_req_retry);
  assign w_accept     = reset && pfmtocore_pred_valid && !w_pred_retry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pend     <= 4'd0;
      r_pfentry  <= '0;
      r_issued   <= 16'd0;
      r_filtered <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        r_rid[i] <= '0;
        r_val[i] <= '0;
        r_w[i]   <= '0;
      end
    end else begin
      if (w_out_xfer) r_issued <= sat_add(r_issued, 3'd1);
      // A new packet can only land when the held one is empty or finishing.
      if (w_accept) begin
        r_filtered <= sat_add(r_filtered, w_nfilt);
        r_pfentry  <= pfmtocore_pred_pfentry;
        r_pend     <= w_new_mask;
        r_state    <= (w_new_mask != 4'd0) ? ISSUE : IDLE;
        for (int i = 0; i < 4; i++) begin
          r_rid[i] <= w_in_rid[i];
          r_val[i] <= w_in_val[i];
          r_w[i]   <= w_in_w[i];
        end
      end else if (w_out_xfer) begin
        r_pend <= r_pend & ~w_sel_bit;
        if (w_onehot) r_state <= IDLE;
      end
    end
  end

  assign pfmtocore_pred_retry  = w_pred_retry;
  assign pfitocore_req_valid   = w_req_valid;
  assign pfitocore_req_pfentry = w_req_valid ? r_pfentry    : '0;
  assign pfitocore_req_rid     = w_req_valid ? r_rid[w_sel] : '0;
  assign pfitocore_req_delta   = w_req_valid ? r_val[w_sel] : '0;
  assign pfitocore_req_w       = w_req_valid ? r_w[w_sel]   : '0;
  assign stat_issued           = reset ? r_issued   : 16'd0;
  assign stat_filtered         = reset ? r_filtered : 16'd0;

endmodule

// File: tb/tb_pfpred_issue.sv
// Directed bench for pfpred_issue: a negedge monitor keeps a request
// scoreboard and counter model while one initial block walks the scenarios.
module tb_pfpred_issue;

  logic        clk;
  logic        reset;
  logic        predValid;
  logic        predRetry;
  logic [9:0]  predPfentry;
  logic [6:0]  dRid [4];
  logic [11:0] dVal [4];
  logic [3:0]  dW   [4];
  logic [3:0]  cfgWthresh;
  logic        reqValid;
  logic        reqRetry;
  logic [9:0]  reqPfentry;
  logic [6:0]  reqRid;
  logic [11:0] reqDelta;
  logic [3:0]  reqW;
  logic [15:0] statIssued;
  logic [15:0] statFiltered;

  typedef struct packed {
    logic [9:0]  pf;
    logic [6:0]  rid;
    logic [11:0] delta;
    logic [3:0]  w;
  } req_t;

  req_t        sb [$];
  logic [15:0] expIssued;
  logic [15:0] expFiltered;
  int          vectors = 0;
  int          fails   = 0;

  pfpred_issue dut (
    .clk                    (clk),
    .reset                  (reset),
    .pfmtocore_pred_valid   (predValid),
    .pfmtocore_pred_retry   (predRetry),
    .pfmtocore_pred_pfentry (predPfentry),
    .pfmtocore_pred_d0_rid  (dRid[0]),
    .pfmtocore_pred_d0_val  (dVal[0]),
    .pfmtocore_pred_d0_w    (dW[0]),
    .pfmtocore_pred_d1_rid  (dRid[1]),
    .pfmtocore_pred_d1_val  (dVal[1]),
    .pfmtocore_pred_d1_w    (dW[1]),
    .pfmtocore_pred_d2_rid  (dRid[2]),
    .pfmtocore_pred_d2_val  (dVal[2]),
    .pfmtocore_pred_d2_w    (dW[2]),
    .pfmtocore_pred_d3_rid  (dRid[3]),
    .pfmtocore_pred_d3_val  (dVal[3]),
    .pfmtocore_pred_d3_w    (dW[3]),
    .cfg_wthresh            (cfgWthresh),
    .pfitocore_req_valid    (reqValid),
    .pfitocore_req_retry    (reqRetry),
    .pfitocore_req_pfentry  (reqPfentry),
    .pfitocore_req_rid      (reqRid),
    .pfitocore_req_delta    (reqDelta),
    .pfitocore_req_w        (reqW),
    .stat_issued            (statIssued),
    .stat_filtered          (statFiltered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] pf, input logic [6:0] ridBase,
                               input logic [47:0] vals, input logic [15:0] ws, input logic [3:0] th);
    predValid   = v;
    predPfentry = pf;
    for (int i = 0; i < 4; i++) begin
      dRid[i] = ridBase + 7'(i);
      dVal[i] = vals[i*12 +: 12];
      dW[i]   = ws[i*4 +: 4];
    end
    cfgWthresh = th;
  endtask

  // Idle input pattern also raises the threshold to prove held packets ignore it.
  task automatic idleInputs;
    applyStimulus(1'b0, 10'd0, 7'd0, 48'd0, 16'd0, 4'hF);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    req_t expReq;
    req_t obsReq;
    int   nf;
    if (!reset) begin
      sb.delete();
      expIssued   = 16'd0;
      expFiltered = 16'd0;
    end else begin
      if (reqValid && !reqRetry) begin
        checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          expReq = sb.pop_front();
          obsReq = '{pf: reqPfentry, rid: reqRid, delta: reqDelta, w: reqW};
          checkOutput("sb_payload", 64'(obsReq), 64'(expReq));
        end
        if (expIssued != 16'hFFFF) expIssued = expIssued + 16'd1;
      end
      if (predValid && !predRetry) begin
        nf = 0;
        for (int i = 0; i < 4; i++) begin
          if (dW[i] >= cfgWthresh && dVal[i] != 12'd0)
            sb.push_back('{pf: predPfentry, rid: dRid[i], delta: dVal[i], w: dW[i]});
          else
            nf++;
        end
        expFiltered = (int'(expFiltered) + nf > 65535) ? 16'hFFFF : expFiltered + 16'(nf);
      end
    end
  end

  initial begin
    int accepted;
    int budget;
    reset    = 1'b0;
    reqRetry = 1'b0;
    // Valid packet offered during reset must be ignored.
    applyStimulus(1'b1, 10'h3A5, 7'h10, {4{12'hABC}}, 16'hFFFF, 4'd0);
    repeat (3) begin
      nextCycle;
      checkOutput("rst_req_valid", reqValid, 1'b0);
      checkOutput("rst_pred_retry", predRetry, 1'b0);
      checkOutput("rst_stat_issued", statIssued, 16'd0);
      checkOutput("rst_stat_filtered", statFiltered, 16'd0);
    end
    nextCycle;
    reset = 1'b1;
    idleInputs();
    #1;
    checkOutput("post_rst_req_valid", reqValid, 1'b0);
    checkOutput("post_rst_pred_retry", predRetry, 1'b0);
    checkOutput("post_rst_stat_issued", statIssued, 16'd0);

    // Weights {5,3,4,7} against threshold 4: slots 0,2,3 issue back to back.
    nextCycle;
    applyStimulus(1'b1, 10'h155, 7'h20, {12'h444, 12'h333, 12'h222, 12'h111}, {4'd7, 4'd4, 4'd3, 4'd5}, 4'd4);
    #1;
    checkOutput("p1_accept_retry", predRetry, 1'b0);
    nextCycle;
    idleInputs();
    #1;
    checkOutput("p1_s0_valid", reqValid, 1'b1);
    checkOutput("p1_s0_rid", reqRid, 7'h20);
    checkOutput("p1_s0_pfentry", reqPfentry, 10'h155);
    checkOutput("p1_s0_pred_retry", predRetry, 1'b1);
    nextCycle;
    checkOutput("p1_s2_valid", reqValid, 1'b1);
    checkOutput("p1_s2_delta", reqDelta, 12'h333);
    checkOutput("p1_s2_pred_retry", predRetry, 1'b1);
    nextCycle;
    checkOutput("p1_s3_valid", reqValid, 1'b1);
    checkOutput("p1_s3_rid", reqRid, 7'h23);
    checkOutput("p1_s3_pred_retry", predRetry, 1'b0);
    nextCycle;
    checkOutput("p1_done_valid", reqValid, 1'b0);
    checkOutput("p1_done_rid_zero", reqRid, 7'd0);
    checkOutput("p1_stat_issued", statIssued, 16'd3);
    checkOutput("p1_stat_filtered", statFiltered, 16'd1);

    // Fully filtered packet, then the next one accepted the following cycle.
    nextCycle;
    applyStimulus(1'b1, 10'h0AA, 7'h30, {4{12'h0F0}}, {4'd7, 4'd0, 4'd1, 4'd6}, 4'd8);
    #1;
    checkOutput("p2_accept_retry", predRetry, 1'b0);
    nextCycle;
    applyStimulus(1'b1, 10'h2C3, 7'h40, {12'h044, 12'h000, 12'h022, 12'h011}, {4'd2, 4'd12, 4'd10, 4'd9}, 4'd8);
    #1;
    checkOutput("p2_no_request", reqValid, 1'b0);
    checkOutput("p3_accept_retry", predRetry, 1'b0);
    checkOutput("p2_stat_filtered", statFiltered, 16'd5);
    nextCycle;
    idleInputs();
    #1;
    checkOutput("p3_s0_valid", reqValid, 1'b1);
    checkOutput("p3_s0_delta", reqDelta, 12'h011);
    checkOutput("p3_s0_pfentry", reqPfentry, 10'h2C3);
    nextCycle;
    reqRetry = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("p3_hold_valid", reqValid, 1'b1);
      checkOutput("p3_hold_rid", reqRid, 7'h41);
      checkOutput("p3_hold_delta", reqDelta, 12'h022);
      checkOutput("p3_hold_w", reqW, 4'd10);
      checkOutput("p3_hold_pred_retry", predRetry, 1'b1);
      if (k < 4) nextCycle;
    end
    nextCycle;
    reqRetry = 1'b0;
    #1;
    checkOutput("p3_release_delta", reqDelta, 12'h022);
    checkOutput("p3_release_pred_retry", predRetry, 1'b0);
    nextCycle;
    checkOutput("p3_done_valid", reqValid, 1'b0);
    checkOutput("p3_stat_issued", statIssued, 16'd5);

    // Back-to-back packets with two live slots each: no bubble between them.
    nextCycle;
    applyStimulus(1'b1, 10'h101, 7'h50, {12'h504, 12'h503, 12'h502, 12'h501}, {4'd9, 4'd1, 4'd9, 4'd1}, 4'd5);
    #1;
    checkOutput("p4_accept_retry", predRetry, 1'b0);
    nextCycle;
    applyStimulus(1'b1, 10'h202, 7'h60, {12'h604, 12'h603, 12'h602, 12'h601}, {4'd1, 4'd9, 4'd1, 4'd9}, 4'd5);
    #1;
    checkOutput("p4_s1_rid", reqRid, 7'h51);
    checkOutput("p5_blocked_retry", predRetry, 1'b1);
    nextCycle;
    checkOutput("p4_s3_rid", reqRid, 7'h53);
    checkOutput("p5_zero_bubble_accept", predRetry, 1'b0);
    nextCycle;
    idleInputs();
    #1;
    checkOutput("p5_s0_valid", reqValid, 1'b1);
    checkOutput("p5_s0_rid", reqRid, 7'h60);
    nextCycle;
    checkOutput("p5_s2_valid", reqValid, 1'b1);
    checkOutput("p5_s2_rid", reqRid, 7'h62);
    nextCycle;
    checkOutput("p5_done_valid", reqValid, 1'b0);
    checkOutput("p5_stat_issued", statIssued, 16'd9);
    checkOutput("p5_stat_filtered", statFiltered, 16'd11);
    checkOutput("p5_model_issued", statIssued, expIssued);
    checkOutput("p5_model_filtered", statFiltered, expFiltered);

    // Reset with two slots still pending drops them.
    nextCycle;
    applyStimulus(1'b1, 10'h333, 7'h70, {12'h704, 12'h703, 12'h702, 12'h701}, 16'hFFFF, 4'd1);
    nextCycle;
    idleInputs();
    #1;
    checkOutput("p6_s0_rid", reqRid, 7'h70);
    nextCycle;
    checkOutput("p6_s1_rid", reqRid, 7'h71);
    nextCycle;
    reset = 1'b0;
    #1;
    checkOutput("p6_in_reset_valid", reqValid, 1'b0);
    checkOutput("p6_in_reset_pred_retry", predRetry, 1'b0);
    nextCycle;
    reset = 1'b1;
    #1;
    checkOutput("p6_after_valid", reqValid, 1'b0);
    checkOutput("p6_after_pred_retry", predRetry, 1'b0);
    checkOutput("p6_after_issued", statIssued, 16'd0);
    checkOutput("p6_after_filtered", statFiltered, 16'd0);
    repeat (3) begin
      nextCycle;
      checkOutput("p6_dropped_valid", reqValid, 1'b0);
    end

    // Drive 65534 transfers, then 3 more, to reach saturation.
    nextCycle;
    applyStimulus(1'b1, 10'h3FF, 7'h01, {12'hD04, 12'hD03, 12'hD02, 12'hD01}, 16'hFFFF, 4'd1);
    #1;
    accepted = 0;
    budget   = 70000;
    while (budget > 0) begin
      if (!predRetry) begin
        accepted++;
        if (accepted == 16383) break;
      end
      nextCycle;
      budget--;
    end
    checkOutput("sat_full_packets", accepted, 16383);
    nextCycle;
    applyStimulus(1'b1, 10'h3FE, 7'h08, {12'hE04, 12'hE03, 12'hE02, 12'hE01}, {4'd0, 4'd0, 4'd9, 4'd9}, 4'd1);
    #1;
    while (predRetry && budget > 0) begin
      nextCycle;
      budget--;
    end
    checkOutput("sat_tail_accept", predRetry, 1'b0);
    nextCycle;
    idleInputs();
    #1;
    while (reqValid && budget > 0) begin
      nextCycle;
      budget--;
    end
    checkOutput("sat_drain_idle", reqValid, 1'b0);
    checkOutput("sat_preload_issued", statIssued, 16'hFFFE);
    checkOutput("sat_preload_model", statIssued, expIssued);
    nextCycle;
    applyStimulus(1'b1, 10'h3FD, 7'h0C, {12'hF04, 12'hF03, 12'hF02, 12'hF01}, {4'd9, 4'd9, 4'd9, 4'd0}, 4'd1);
    #1;
    checkOutput("sat_last_accept", predRetry, 1'b0);
    nextCycle;
    idleInputs();
    #1;
    budget = 20;
    while (reqValid && budget > 0) begin
      nextCycle;
      budget--;
    end
    checkOutput("sat_last_idle", reqValid, 1'b0);
    checkOutput("sat_issued_ffff", statIssued, 16'hFFFF);
    checkOutput("sat_filtered", statFiltered, 16'd3);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pfpred_issue.md
PFPRED_ISSUE -- requirements
Module: pfpred_issue

Interface
REQ-001 SHALL have parameter PFENTRY_W, default 10: width of the prefetch-table entry index.
REQ-002 SHALL have parameter ROBID_W, default 7: width of the ROB id field.
REQ-003 SHALL have parameter DELTA_W, default 12: width of the signed stride delta.
REQ-004 SHALL have parameter WEIGHT_W, default 4: width of the unsigned confidence weight.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset; state is reset on a clk edge where reset==0.
REQ-007 SHALL have port pfmtocore_pred_valid  input  1  prediction packet valid from the prefetch monitor.
REQ-008 SHALL have port pfmtocore_pred_retry  output  1  back-pressure to the prefetch monitor.
REQ-009 SHALL have port pfmtocore_pred_pfentry  input  PFENTRY_W  entry index of the packet.
REQ-010 SHALL have ports pfmtocore_pred_dN_rid / _dN_val / _dN_w for N=0..3  input  ROBID_W / DELTA_W / WEIGHT_W  four delta slots.
REQ-011 SHALL have port cfg_wthresh  input  WEIGHT_W  minimum weight for a slot to be issued; sampled when a packet is accepted.
REQ-012 SHALL have port pfitocore_req_valid  output  1  prefetch request valid.
REQ-013 SHALL have port pfitocore_req_retry  input  1  downstream back-pressure.
REQ-014 SHALL have ports pfitocore_req_pfentry / _rid / _delta / _w  output  PFENTRY_W / ROBID_W / DELTA_W / WEIGHT_W  request payload.
REQ-015 SHALL have ports stat_issued, stat_filtered  output  16 each  saturating counters.

Function
REQ-016 SHALL treat a transfer on either channel as occurring only in a cycle where valid==1 and retry==0.
REQ-017 SHALL hold one packet in a holding register plus a 4-bit pending mask and a latched threshold; the FSM has two states, IDLE (no packet held) and ISSUE (packet held).
REQ-018 SHALL set pending bit N on acceptance iff dN_w >= cfg_wthresh and dN_val != 0; every cleared bit increments stat_filtered by 1 in that cycle, so a packet can add up to 4.
REQ-019 SHALL in IDLE drive pfmtocore_pred_retry=0 and accept any valid packet; the FSM then goes to ISSUE, or stays in IDLE if the pending mask is all-zero.
REQ-020 SHALL in ISSUE drive pfitocore_req_valid=1 with the payload of the lowest-numbered pending slot, plus the held pfentry.
REQ-021 SHALL keep the request payload stable while pfitocore_req_valid==1 and pfitocore_req_retry==1.
REQ-022 SHALL on each output transfer clear that slot's pending bit and increment stat_issued.
REQ-023 SHALL in ISSUE drive pfmtocore_pred_retry = !(exactly one pending bit remains AND pfitocore_req_retry==0); this is a combinational path from pfitocore_req_retry and is allowed.
REQ-024 SHALL accept a new packet in the same cycle the last pending slot transfers (zero-bubble); the FSM stays in ISSUE with the new mask, or goes to IDLE if the new mask is zero.
REQ-025 SHALL deliver the first request of a packet accepted in cycle N as valid in cycle N+1; slots are issued in order 0,1,2,3, skipping cleared slots.
REQ-026 SHALL keep pfitocore_req_valid=0 in IDLE, with payload outputs driven to 0.
REQ-027 SHALL saturate both stat counters at 16'hFFFF, never wrapping.
REQ-028 SHALL keep cfg_wthresh changes from affecting a packet already held.

Reset
REQ-029 SHALL on a clk edge with reset==0 enter IDLE, clear the pending mask, holding register and both counters, and drop any held packet without issuing it.
REQ-030 SHALL during reset and in the first cycle after it drive pfitocore_req_valid=0, pfmtocore_pred_retry=0, stat_issued=0 and stat_filtered=0.
REQ-031 SHALL ignore pfmtocore_pred_valid in any cycle where reset==0.

Verification
REQ-032 SHALL cover: thresh=4, packet weights {5,3,4,7}, all deltas nonzero, no output retry -> requests for slots 0,2,3 in consecutive cycles N+1..N+3; stat_issued=3; stat_filtered=1.
REQ-033 SHALL cover: packet with all weights below threshold -> no request; retry stays 0; stat_filtered=+4; a next packet is accepted the following cycle.
REQ-034 SHALL cover: pfitocore_req_retry held 1 for 5 cycles during slot 1 -> payload stable for all 5 cycles; pfmtocore_pred_retry=1 throughout; slot 1 issued once.
REQ-035 SHALL cover: back-to-back packets, each with 2 qualifying slots -> 4 requests in 4 consecutive cycles with no bubble; the second packet is accepted in the cycle of the first packet's last transfer.
REQ-036 SHALL cover: reset==0 asserted while 2 slots are still pending -> next cycle valid=0 and counters=0; the dropped slots are never issued.
REQ-037 SHALL cover: stat_issued preloaded to 16'hFFFE by driving 65534 transfers, then 3 more transfers -> counter reads 16'hFFFF.
